ac97_codec_responder: RTL and testbench
=======================================

Name: ac97_codec_responder

Overview:
- Codec-side AC97 link endpoint, bit_clk domain: decodes controller frames on sync/sdata_out and returns frames on sdata_in.
- Holds a 64 x 16-bit codec register file written and read through slots 1/2.
- Delivers received PCM (slots 3/4) to a sink and sends a mic sample from a source in slot 3.
- Used as an in-fabric codec stand-in for controller bring-up and loopback tests.

Parameters:
- CODEC_READY_FRAMES, 4, complete frames after reset before tag bit 15 (codec ready) is driven high.
- VENDOR_ID1, 16'h4144, read-only value at register 0x7C.
- VENDOR_ID2, 16'h5370, read-only value at register 0x7E.

Ports:
- bit_clk  in  1  sole clock; every register is updated on the rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- sync  in  1  frame sync from the controller.
- sdata_out  in  1  serial data from the controller.
- sdata_in  out  1  serial data to the controller.
- mic_sample  in  20  next slot-3 sample.
- mic_valid  in  1  mic_sample is available.
- mic_rd_en  out  1  one-cycle pop of mic_sample.
- pcm_left  out  20  last received slot 3.
- pcm_right  out  20  last received slot 4.
- pcm_valid  out  1  one-cycle pulse when pcm_left/pcm_right update.
- master_vol  out  16  register 0x02.
- pcm_vol  out  16  register 0x18.
- frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset values: all outputs 0; state IDLE; register file at defaults (0x02, 0x04 = 16'h8000; 0x18 = 16'h8808; 0x26 = 16'h000F; 0x7C/0x7E = VENDOR_IDs; all others 0); ready counter 0; no read response pending.
- Capture: sync and sdata_out are sampled on the rising edge. Frame bit 0 is the edge at which sync is seen high while its previous sample was low. Bit i is captured i edges later; bit 0 is the MSB of tag.
- States:
  - IDLE -> RUN on a sync rise; the bit counter is set to 0.
  - RUN counts 0..255. At 255, a sync rise on the next edge starts a new frame; otherwise go to IDLE.
  - A sync rise at counter < 255 (early restart): frame_err pulses, any partial command is discarded, counter restarts at 0.
  - sync low at any counter value 1..15: frame_err pulses; the frame is still processed.
- TX: on the edge that captures bit i, sdata_in drives TX bit i (zero latency relative to capture). In IDLE, sdata_in = 0.
- TX frame is built at bit 0 from state latched at the end of the previous frame:
  - Tag bits 15..11 = {ready, resp, resp, mic_ok, 0}; bits 10..0 = 0.
  - Slot 1 = {0, addr7, 12'b0}.
  - Slot 2 = {data16, 4'b0}.
  - Slot 3 = mic sample if mic_ok, else 0.
  - Slots 4..12 = 0.
- mic_ok = mic_valid sampled at bit 0. If set, mic_rd_en pulses on that same edge.
- Command decode at capture of bit 55, the last bit of slot 2. Tag valid bits: rx[15] frame valid, rx[14] slot 1 valid, rx[13] slot 2 valid.
  - Read: rx[15] & rx[14] & slot1[19] = 1. Latch addr and reg data; resp = 1 for the next frame only.
  - Write: rx[15] & rx[14] & rx[13] & slot1[19] = 0. Write slot2[19:4] to addr.
  - Writes to 0x26, 0x7C, 0x7E are ignored. A write to 0x00 restores all defaults.
  - Odd addresses use addr[6:1] (the LSB is ignored).
- PCM: at bit 95 capture, if rx[12], update pcm_left. At bit 115, if rx[11], update pcm_right. pcm_valid pulses at bit 115 if rx[12] or rx[11] was set.
- ready: the counter increments on each completed frame (bit 255 reached) until it equals CODEC_READY_FRAMES, then saturates; ready = 1 from then on.
- reset_b asserted mid-frame: immediate return to reset values; nothing is decoded.

Decomposition:
- Shared package ac97_pkg: slot bit offsets (SLOT0 = 0, SLOT1 = 16, SLOT2 = 36, SLOT3 = 56, SLOT4 = 76), tag bit indices, register addresses (0x00, 0x02, 0x04, 0x0E, 0x18, 0x1A, 0x1C, 0x26, 0x7C, 0x7E), default values, FRAME_BITS = 256.
- Sub-module ac97_codec_regfile holds the 64 x 16 storage: one write port, one read port, a soft-reset-to-defaults input, and read-only masking.

Test Plan:
- Reset, then send 4 frames with tag 5'b10000 -> tag bit 15 = 0 in frames 1..4 and = 1 from frame 5; sdata_in = 0 in IDLE.
- Write frame: tag 11111, slot1 = {0,7'h02,12'b0}, slot2 = {16'h0808,4'b0} -> master_vol = 16'h0808 after bit 55.
- Read 0x7C -> the next TX frame has tag bits 14/13 set, slot1 addr 0x7C, slot2 = {16'h4144,4'b0}; the frame after has them clear.
- Slots 3/4 = 20'h12345 / 20'hABCDE with tag bits 12/11 set -> pcm_left/pcm_right match and pcm_valid pulses once, at bit 115.
- mic_valid = 1, mic_sample = 20'h00F0F -> mic_rd_en pulses at bit 0; slot 3 carries 20'h00F0F with tag bit 12 set. With mic_valid = 0, slot 3 = 0 and tag bit 12 = 0.
- sync rise at bit 100 -> frame_err pulses; a write present in that frame is decoded (bit 55 already passed). Write 0x00 -> master_vol returns to 16'h8000. Write 0x7C -> readback is unchanged.

Source files
------------

// File: rtl/ac97_pkg.sv
// Shared AC97 link constants: slot layout, tag bits, codec register map and
// power-on register defaults.
package ac97_pkg;

    localparam int FRAME_BITS = 256;
    localparam int SLOT_BITS  = 20;

    localparam int SLOT0 = 0;
    localparam int SLOT1 = 16;
    localparam int SLOT2 = 36;
    localparam int SLOT3 = 56;
    localparam int SLOT4 = 76;

    // Capture points (frame bit index) at which fields become complete
    localparam int TAG_END   = SLOT1 - 1;
    localparam int SLOT1_END = SLOT2 - 1;
    localparam int CMD_BIT   = SLOT3 - 1;
    localparam int PCM_L_BIT = SLOT4 + SLOT_BITS - 1;
    localparam int PCM_R_BIT = SLOT4 + 2 * SLOT_BITS - 1;

    localparam int TAG_FRAME = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;
    localparam int TAG_SLOT3 = 12;
    localparam int TAG_SLOT4 = 11;

    localparam logic [6:0] REG_RESET      = 7'h00;
    localparam logic [6:0] REG_MASTER_VOL = 7'h02;
    localparam logic [6:0] REG_HP_VOL     = 7'h04;
    localparam logic [6:0] REG_MIC_VOL    = 7'h0E;
    localparam logic [6:0] REG_PCM_VOL    = 7'h18;
    localparam logic [6:0] REG_REC_SEL    = 7'h1A;
    localparam logic [6:0] REG_REC_GAIN   = 7'h1C;
    localparam logic [6:0] REG_POWERDOWN  = 7'h26;
    localparam logic [6:0] REG_VENDOR_ID1 = 7'h7C;
    localparam logic [6:0] REG_VENDOR_ID2 = 7'h7E;

    localparam logic [15:0] DEF_MASTER_VOL = 16'h8000;
    localparam logic [15:0] DEF_HP_VOL     = 16'h8000;
    localparam logic [15:0] DEF_PCM_VOL    = 16'h8808;
    localparam logic [15:0] DEF_POWERDOWN  = 16'h000F;

    typedef enum logic {ST_IDLE, ST_RUN} link_state_t;

    function automatic logic [15:0] reg_default(input logic [5:0] word,
                                                input logic [15:0] vid1,
                                                input logic [15:0] vid2);
        logic [15:0] val;
        val = 16'h0000;
        if (word == REG_MASTER_VOL[6:1]) val = DEF_MASTER_VOL;
        if (word == REG_HP_VOL[6:1])     val = DEF_HP_VOL;
        if (word == REG_PCM_VOL[6:1])    val = DEF_PCM_VOL;
        if (word == REG_POWERDOWN[6:1])  val = DEF_POWERDOWN;
        if (word == REG_VENDOR_ID1[6:1]) val = vid1;
        if (word == REG_VENDOR_ID2[6:1]) val = vid2;
        return val;
    endfunction

    function automatic logic is_read_only(input logic [5:0] word);
        return (word == REG_POWERDOWN[6:1]) || (word == REG_VENDOR_ID1[6:1]) ||
               (word == REG_VENDOR_ID2[6:1]);
    endfunction

endpackage

// File: rtl/ac97_codec_regfile.sv
// 64 x 16 codec register file: one write port, registered read port,
// soft reset to defaults and write masking of read-only registers.
module ac97_codec_regfile
    import ac97_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID1 = 16'h4144,
    parameter logic [15:0] VENDOR_ID2 = 16'h5370
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_rst,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [5:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [15:0] master_vol,
    output logic [15:0] pcm_vol
);

    logic [15:0] mem [64];
    logic [63:0] writable;

    for (genvar gi = 0; gi < 64; gi++) begin : g_wmask
        assign writable[gi] = !is_read_only(6'(gi));
    end

    // Storage needs a reset, so it lives in flops rather than block RAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= reg_default(6'(i), VENDOR_ID1, VENDOR_ID2);
        end else if (soft_rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= reg_default(6'(i), VENDOR_ID1, VENDOR_ID2);
        end else if (wr_en && writable[wr_addr]) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= 16'h0000;
        else        rd_data <= mem[rd_addr];
    end

    assign master_vol = mem[REG_MASTER_VOL[6:1]];
    assign pcm_vol    = mem[REG_PCM_VOL[6:1]];

endmodule

// File: rtl/ac97_codec_responder.sv
// Codec-side AC97 link endpoint: decodes controller frames on sync/sdata_out,
// serves register reads/writes, delivers PCM and returns mic data on sdata_in.
module ac97_codec_responder
    import ac97_pkg::*;
#(
    parameter int          CODEC_READY_FRAMES = 4,
    parameter logic [15:0] VENDOR_ID1         = 16'h4144,
    parameter logic [15:0] VENDOR_ID2         = 16'h5370
) (
    input  logic        bit_clk,
    input  logic        reset_b,
    input  logic        sync,
    input  logic        sdata_out,
    output logic        sdata_in,
    input  logic [19:0] mic_sample,
    input  logic        mic_valid,
    output logic        mic_rd_en,
    output logic [19:0] pcm_left,
    output logic [19:0] pcm_right,
    output logic        pcm_valid,
    output logic [15:0] master_vol,
    output logic [15:0] pcm_vol,
    output logic        frame_err
);

    localparam int RDY_W   = $clog2(CODEC_READY_FRAMES + 2);
    localparam int TX_BITS = SLOT4;   // slots 4..12 are always zero

    link_state_t        state_reg;
    logic [7:0]         bit_cnt_reg;
    logic               sync_prev_reg;
    logic [38:0]        rx_shift_reg;
    logic [39:0]        rx_next;
    logic [4:0]         tag_reg;      // received tag bits 15..11
    logic [7:0]         slot1_reg;    // {read flag, addr7}
    logic [TX_BITS-1:0] tx_shift_reg;
    logic [TX_BITS-1:0] tx_frame;
    logic [RDY_W-1:0]   ready_cnt_reg;
    logic               resp_reg;
    logic [6:0]         resp_addr_reg;
    logic [15:0]        resp_data_reg;

    logic        sync_rise, active, ready;
    logic [7:0]  idx;
    logic        cmd_edge, wr_cmd, rd_cmd, soft_rst, err_now;
    logic [15:0] rd_data, reg_master, reg_pcm;

    assign sync_rise = sync & ~sync_prev_reg;
    assign rx_next   = {rx_shift_reg, sdata_out};
    assign ready     = (ready_cnt_reg == RDY_W'(CODEC_READY_FRAMES));

    // idx is the frame bit captured on this edge; active is low outside a frame
    always_comb begin
        active = 1'b0;
        idx    = 8'd0;
        if (sync_rise) begin
            active = 1'b1;
        end else if (state_reg == ST_RUN && bit_cnt_reg != 8'(FRAME_BITS - 1)) begin
            active = 1'b1;
            idx    = bit_cnt_reg + 8'd1;
        end
    end

    assign cmd_edge = active && (idx == 8'(CMD_BIT));
    assign wr_cmd   = cmd_edge && tag_reg[TAG_FRAME-11] && tag_reg[TAG_SLOT1-11] &&
                      tag_reg[TAG_SLOT2-11] && !slot1_reg[7];
    assign rd_cmd   = cmd_edge && tag_reg[TAG_FRAME-11] && tag_reg[TAG_SLOT1-11] && slot1_reg[7];
    assign soft_rst = wr_cmd && (slot1_reg[6:1] == REG_RESET[6:1]);

    assign err_now = (sync_rise && state_reg == ST_RUN && bit_cnt_reg != 8'(FRAME_BITS - 1)) ||
                     (active && !sync && idx >= 8'd1 && idx <= 8'(TAG_END));

    assign tx_frame = {ready, resp_reg, resp_reg, mic_valid, 12'b0,
                       resp_reg ? {1'b0, resp_addr_reg, 12'b0} : 20'b0,
                       resp_reg ? {resp_data_reg, 4'b0} : 20'b0,
                       mic_valid ? mic_sample : 20'b0};

    ac97_codec_regfile #(
        .VENDOR_ID1 (VENDOR_ID1),
        .VENDOR_ID2 (VENDOR_ID2)
    ) u_regfile (
        .clk        (bit_clk),
        .rst_n      (reset_b),
        .soft_rst   (soft_rst),
        .wr_en      (wr_cmd && !soft_rst),
        .wr_addr    (slot1_reg[6:1]),
        .wr_data    (rx_next[19:4]),
        .rd_addr    (slot1_reg[6:1]),
        .rd_data    (rd_data),
        .master_vol (reg_master),
        .pcm_vol    (reg_pcm)
    );

    always_ff @(posedge bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 8'd0;
            sync_prev_reg <= 1'b0;
            rx_shift_reg  <= '0;
            tag_reg       <= '0;
            slot1_reg     <= '0;
            tx_shift_reg  <= '0;
            ready_cnt_reg <= '0;
            resp_reg      <= 1'b0;
            resp_addr_reg <= '0;
            resp_data_reg <= '0;
            sdata_in      <= 1'b0;
            mic_rd_en     <= 1'b0;
            pcm_left      <= '0;
            pcm_right     <= '0;
            pcm_valid     <= 1'b0;
            master_vol    <= '0;
            pcm_vol       <= '0;
            frame_err     <= 1'b0;
        end else begin
            sync_prev_reg <= sync;
            frame_err     <= err_now;
            mic_rd_en     <= 1'b0;
            pcm_valid     <= 1'b0;
            master_vol    <= reg_master;
            pcm_vol       <= reg_pcm;
            if (active) begin
                state_reg    <= ST_RUN;
                bit_cnt_reg  <= idx;
                rx_shift_reg <= rx_next[38:0];
                if (idx == 8'd0) begin
                    sdata_in     <= tx_frame[TX_BITS-1];
                    tx_shift_reg <= {tx_frame[TX_BITS-2:0], 1'b0};
                    resp_reg     <= 1'b0;
                    mic_rd_en    <= mic_valid;
                end else begin
                    sdata_in     <= tx_shift_reg[TX_BITS-1];
                    tx_shift_reg <= {tx_shift_reg[TX_BITS-2:0], 1'b0};
                end
                if (idx == 8'(TAG_END))   tag_reg   <= rx_next[15:11];
                if (idx == 8'(SLOT1_END)) slot1_reg <= rx_next[19:12];
                if (rd_cmd) begin
                    resp_reg      <= 1'b1;
                    resp_addr_reg <= slot1_reg[6:0];
                    resp_data_reg <= rd_data;
                end
                if (idx == 8'(PCM_L_BIT) && tag_reg[TAG_SLOT3-11]) pcm_left <= rx_next[39:20];
                if (idx == 8'(PCM_R_BIT)) begin
                    if (tag_reg[TAG_SLOT4-11]) pcm_right <= rx_next[39:20];
                    pcm_valid <= tag_reg[TAG_SLOT3-11] | tag_reg[TAG_SLOT4-11];
                end
                if (idx == 8'(FRAME_BITS - 1) && !ready)
                    ready_cnt_reg <= ready_cnt_reg + RDY_W'(1);
            end else begin
                state_reg <= ST_IDLE;
                sdata_in  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ac97_codec_responder.sv
// Directed bench for ac97_codec_responder: drives whole controller frames and
// checks returned frames, register side effects, PCM and error pulses.
module tb_ac97_codec_responder;

    logic        bit_clk;
    logic        reset_b;
    logic        sync;
    logic        sdata_out;
    logic        sdata_in;
    logic [19:0] mic_sample;
    logic        mic_valid;
    logic        mic_rd_en;
    logic [19:0] pcm_left;
    logic [19:0] pcm_right;
    logic        pcm_valid;
    logic [15:0] master_vol;
    logic [15:0] pcm_vol;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int pv_cnt = 0, pv_idx = -1;
    int mr_cnt = 0, mr_idx = -1;
    int err_base;
    logic [255:0] got;

    ac97_codec_responder dut (
        .bit_clk    (bit_clk),
        .reset_b    (reset_b),
        .sync       (sync),
        .sdata_out  (sdata_out),
        .sdata_in   (sdata_in),
        .mic_sample (mic_sample),
        .mic_valid  (mic_valid),
        .mic_rd_en  (mic_rd_en),
        .pcm_left   (pcm_left),
        .pcm_right  (pcm_right),
        .pcm_valid  (pcm_valid),
        .master_vol (master_vol),
        .pcm_vol    (pcm_vol),
        .frame_err  (frame_err)
    );

    initial bit_clk = 1'b0;
    always #5 bit_clk = ~bit_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] frm(input logic [15:0] t, input logic [19:0] s1,
                                         input logic [19:0] s2, input logic [19:0] s3,
                                         input logic [19:0] s4);
        return {t, s1, s2, s3, s4, 160'b0};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        pv_cnt = 0; pv_idx = -1; mr_cnt = 0; mr_idx = -1;
    endtask

    // Sends len bits of f (bit 0 first); sdata_in is captured #1 after each edge
    task automatic send_frame(input logic [255:0] f, input int len, input int sync_bits,
                              output logic [255:0] rx);
        rx = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge bit_clk);
            sync      = (i < sync_bits);
            sdata_out = f[255-i];
            @(posedge bit_clk);
            #1;
            rx[255-i] = sdata_in;
            if (frame_err) err_cnt++;
            if (pcm_valid) begin pv_cnt++; pv_idx = i; end
            if (mic_rd_en) begin mr_cnt++; mr_idx = i; end
        end
    endtask

    initial begin
        reset_b = 1'b0; sync = 1'b0; sdata_out = 1'b0;
        mic_valid = 1'b0; mic_sample = 20'h0;
        repeat (3) @(posedge bit_clk);
        #1;
        check("rst_sdata_in", 256'(sdata_in), 256'(1'b0));
        check("rst_master_vol", 256'(master_vol), 256'(16'h0000));
        check("rst_pcm_left", 256'(pcm_left), 256'(20'h0));
        check("rst_frame_err", 256'(frame_err), 256'(1'b0));
        @(negedge bit_clk) reset_b = 1'b1;
        repeat (3) @(posedge bit_clk);
        #1;
        check("dflt_master_vol", 256'(master_vol), 256'(16'h8000));
        check("dflt_pcm_vol", 256'(pcm_vol), 256'(16'h8808));
        check("idle_sdata_in", 256'(sdata_in), 256'(1'b0));

        // Frames 1..4: codec not ready yet
        for (int f = 1; f <= 4; f++) begin
            send_frame(frm(16'h8000, 0, 0, 0, 0), 256, 16, got);
            check($sformatf("notready_frame%0d", f), got, 256'b0);
        end
        repeat (3) @(posedge bit_clk);
        #1;
        check("idle_after_frames", 256'(sdata_in), 256'(1'b0));

        // Frame 5: ready, write master_vol = 0x0808
        send_frame(frm(16'hF800, 20'h02000, 20'h08080, 0, 0), 256, 16, got);
        check("ready_frame5", got, frm(16'h8000, 0, 0, 0, 0));
        check("write_master_vol", 256'(master_vol), 256'(16'h0808));

        // Read 0x7C, response in following frame only
        send_frame(frm(16'hC000, 20'hFC000, 0, 0, 0), 256, 16, got);
        check("read_req_frame_tx", got, frm(16'h8000, 0, 0, 0, 0));
        send_frame(frm(16'h8000, 0, 0, 0, 0), 256, 16, got);
        check("read_resp_7c", got, frm(16'hE000, 20'h7C000, 20'h41440, 0, 0));
        send_frame(frm(16'h8000, 0, 0, 0, 0), 256, 16, got);
        check("resp_cleared", got, frm(16'h8000, 0, 0, 0, 0));

        // PCM slots 3/4
        clear_counts();
        send_frame(frm(16'h9800, 0, 0, 20'h12345, 20'hABCDE), 256, 16, got);
        check("pcm_left", 256'(pcm_left), 256'(20'h12345));
        check("pcm_right", 256'(pcm_right), 256'(20'hABCDE));
        check("pcm_valid_count", 256'(pv_cnt), 256'(1));
        check("pcm_valid_bit", 256'(pv_idx), 256'(115));

        // Mic sample returned in slot 3
        clear_counts();
        mic_valid = 1'b1; mic_sample = 20'h00F0F;
        send_frame(frm(16'h8000, 0, 0, 0, 0), 256, 16, got);
        check("mic_tx_frame", got, frm(16'h9000, 0, 0, 20'h00F0F, 0));
        check("mic_rd_count", 256'(mr_cnt), 256'(1));
        check("mic_rd_bit", 256'(mr_idx), 256'(0));
        clear_counts();
        mic_valid = 1'b0; mic_sample = 20'hFFFFF;
        send_frame(frm(16'h8000, 0, 0, 0, 0), 256, 16, got);
        check("nomic_tx_frame", got, frm(16'h8000, 0, 0, 0, 0));
        check("nomic_rd_count", 256'(mr_cnt), 256'(0));

        // Early restart at bit 100; the write in that frame was already decoded
        err_base = err_cnt;
        send_frame(frm(16'hF800, 20'h18000, 20'h12340, 0, 0), 100, 16, got);
        check("early_write_pcm_vol", 256'(pcm_vol), 256'(16'h1234));
        send_frame(frm(16'hF800, 20'h00000, 20'h0FFF0, 0, 0), 256, 16, got);
        check("early_restart_err", 256'(err_cnt - err_base), 256'(1));
        check("soft_rst_master", 256'(master_vol), 256'(16'h8000));
        check("soft_rst_pcm_vol", 256'(pcm_vol), 256'(16'h8808));

        // Write to read-only 0x7C ignored; readback of 0x7C then 0x02
        send_frame(frm(16'hF800, 20'h7C000, 20'hFFFF0, 0, 0), 256, 16, got);
        send_frame(frm(16'hC000, 20'hFC000, 0, 0, 0), 256, 16, got);
        send_frame(frm(16'hC000, 20'h82000, 0, 0, 0), 256, 16, got);
        check("ro_7c_readback", got, frm(16'hE000, 20'h7C000, 20'h41440, 0, 0));
        // Odd address 0x03 aliases register 0x02
        send_frame(frm(16'hF800, 20'h03000, 20'hBEEF0, 0, 0), 256, 16, got);
        check("read_02_after_soft", got, frm(16'hE000, 20'h02000, 20'h80000, 0, 0));
        check("odd_addr_write", 256'(master_vol), 256'(16'hBEEF));

        // sync dropped at bit 8: error flagged, frame still processed
        err_base = err_cnt;
        send_frame(frm(16'hF800, 20'h18000, 20'h55550, 0, 0), 256, 8, got);
        check("short_sync_err", 256'(err_cnt != err_base), 256'(1'b1));
        check("short_sync_write", 256'(pcm_vol), 256'(16'h5555));

        @(negedge bit_clk) sync = 1'b0;
        repeat (3) @(posedge bit_clk);
        #1;
        check("final_idle_sdata_in", 256'(sdata_in), 256'(1'b0));
        check("final_idle_err", 256'(frame_err), 256'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
